// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, baud divisor helper.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive-line front end: 2-flop synchroniser, falling-edge detect and
// 3-tap majority vote over the last three synchronised samples.
module uart_rx_sampler (
   input  logic clk,
   input  logic reset,
   input  logic rx_line,
   output logic rx_s,
   output logic fall,
   output logic maj
);

   logic sync1;
   logic sync2;
   logic hist1;
   logic hist2;

   // Idle-high line: everything resets to 1 so reset release never looks like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         hist1 <= 1'b1;
         hist2 <= 1'b1;
      end else begin
         sync1 <= rx_line;
         sync2 <= sync1;
         hist1 <= sync2;
         hist2 <= hist1;
      end
   end

   assign rx_s = sync2;
   assign fall = hist1 & ~sync2;
   assign maj  = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with one-entry valid/ready holding register.
// Optional break detection when UART_RX_BREAK_DET_EN is defined.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_line,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
`ifdef UART_RX_BREAK_DET_EN
   output logic                 rx_break,
`endif
   output logic                 rx_busy
);

   localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W = $clog2(CPB + 1);
   localparam int unsigned BIT_W = 4;
   localparam parity_e     PAR_CFG  = parity_e'(2'(PARITY));
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CPB / 2 + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPB - 1);

   rx_state_e            state;
   rx_state_e            state_next;
   logic [CNT_W-1:0]     clk_count;
   logic [BIT_W-1:0]     bit_count;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_err_q;
   logic                 frm_err_q;
   logic                 frame_done;
   logic                 fall;
   logic                 maj;
   logic                 tick;
   logic                 last_data;
   logic                 last_stop;
   logic                 frame_end;
   logic                 start_det;
`ifdef UART_RX_BREAK_DET_EN
   logic                 rx_s;
   logic                 any_one;
   logic                 brk_wait;
   logic                 is_break;
`endif

   uart_rx_sampler u_sampler (
      .clk     (clk),
      .reset   (reset),
      .rx_line (rx_line),
`ifdef UART_RX_BREAK_DET_EN
      .rx_s    (rx_s),
`else
      .rx_s    (),
`endif
      .fall    (fall),
      .maj     (maj)
   );

   assign tick      = (clk_count == MID_CNT);
   assign last_data = (bit_count == BIT_W'(DATA_BITS - 1));
   assign last_stop = (bit_count == BIT_W'(STOP_BITS - 1));
   assign frame_end = (state == ST_STOP) && tick && last_stop;
`ifdef UART_RX_BREAK_DET_EN
   assign start_det = fall & ~brk_wait;
   assign is_break  = frame_end & ~any_one & ~maj;
`else
   assign start_det = fall;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (start_det) state_next = ST_START;
         ST_START:  if (tick) state_next = maj ? ST_IDLE : ST_DATA;
         ST_DATA:   if (tick && last_data)
                       state_next = (PAR_CFG != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (tick) state_next = ST_STOP;
         ST_STOP:   if (tick && last_stop) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Bit timing, shifter and per-frame error accumulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_count  <= '0;
         bit_count  <= '0;
         shift_reg  <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         frame_done <= 1'b0;
         rx_busy    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         any_one    <= 1'b0;
         brk_wait   <= 1'b0;
         rx_break   <= 1'b0;
`endif
      end else begin
         rx_busy <= (state_next != ST_IDLE);
         if (state != ST_IDLE && state_next != ST_IDLE)
            clk_count <= (clk_count == LAST_CNT) ? '0 : clk_count + CNT_W'(1);
`ifdef UART_RX_BREAK_DET_EN
         else if (brk_wait && rx_s && clk_count != LAST_CNT)
            clk_count <= clk_count + CNT_W'(1);
`endif
         else
            clk_count <= '0;

         if (state == ST_IDLE && start_det) begin
            bit_count <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            any_one   <= 1'b0;
`endif
         end

         if (tick) begin
            case (state)
               ST_DATA: begin
                  shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                  bit_count <= last_data ? '0 : bit_count + BIT_W'(1);
               end
               ST_PARITY: par_err_q <= (^shift_reg) ^ maj ^ (PAR_CFG == PAR_ODD);
               ST_STOP: begin
                  if (!maj) frm_err_q <= 1'b1;
                  bit_count <= last_stop ? '0 : bit_count + BIT_W'(1);
               end
               default: ;
            endcase
         end

`ifdef UART_RX_BREAK_DET_EN
         if (tick && maj && (state inside {ST_DATA, ST_PARITY, ST_STOP})) any_one <= 1'b1;
         frame_done <= frame_end & ~is_break;
         rx_break   <= is_break;
         // After a break, re-arm only once the line has been high for a full bit.
         if (is_break) brk_wait <= 1'b1;
         else if (state == ST_IDLE && rx_s && clk_count == LAST_CNT) brk_wait <= 1'b0;
`else
         frame_done <= frame_end;
`endif
      end
   end

   // One-entry holding register; a new word beats a same-cycle accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (frame_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data       <= shift_reg;
               rx_frame_err  <= frm_err_q;
               rx_parity_err <= par_err_q;
               rx_valid      <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
